// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - oversampling serial byte receiver with valid/ready output
module rx_frame_ctrl #(
  parameter int CLKS_PER_TICK = 4,
  parameter int OVERSAMPLE    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_idle,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] TICK_LAST = 8'(CLKS_PER_TICK - 1);
  localparam logic [3:0] OS_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] OS_MID    = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [4:0] ONES_HALF = 5'(OVERSAMPLE / 2);

  logic       rx_meta, rx_s;
  logic [7:0] tick_cnt;
  logic       tick;

  state_t     state, state_d;
  logic [3:0] os_cnt, os_d;
  logic [2:0] bit_idx, bit_d;
  logic [4:0] ones_cnt, ones_d;
  logic [7:0] shreg, shreg_d;
  logic [4:0] ones_sum;
  logic       bit_val;
  logic       frame_done;
  logic       stop_bad;

  // Two-flop synchronizer; the line idles high so the flops reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Free-running oversample tick divider, independent of receiver state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= 8'd0;
    end else if (tick) begin
      tick_cnt <= 8'd0;
    end else begin
      tick_cnt <= tick_cnt + 8'd1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // The decision for a data bit includes the sample taken on its last tick.
  assign ones_sum = ones_cnt + {4'd0, rx_s};
  assign bit_val  = (ones_sum >= ONES_HALF);

  // Receiver state and bit-timing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      os_cnt   <= 4'd0;
      bit_idx  <= 3'd0;
      ones_cnt <= 5'd0;
      shreg    <= 8'd0;
    end else begin
      state    <= state_d;
      os_cnt   <= os_d;
      bit_idx  <= bit_d;
      ones_cnt <= ones_d;
      shreg    <= shreg_d;
    end
  end

  // Next-state logic; all progress happens on ticks only.
  always_comb begin
    state_d    = state;
    os_d       = os_cnt;
    bit_d      = bit_idx;
    ones_d     = ones_cnt;
    shreg_d    = shreg;
    frame_done = 1'b0;
    stop_bad   = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            os_d    = 4'd0;
            state_d = START;
          end
        end
        START: begin
          if (os_cnt == OS_MID && rx_s) begin
            state_d = IDLE;
          end else if (os_cnt == OS_LAST) begin
            state_d = DATA;
            os_d    = 4'd0;
            bit_d   = 3'd0;
            ones_d  = 5'd0;
          end else begin
            os_d = os_cnt + 4'd1;
          end
        end
        DATA: begin
          if (os_cnt == OS_LAST) begin
            os_d    = 4'd0;
            ones_d  = 5'd0;
            shreg_d = {bit_val, shreg[7:1]};
            bit_d   = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state_d = STOP;
            end
          end else begin
            os_d   = os_cnt + 4'd1;
            ones_d = ones_sum;
          end
        end
        STOP: begin
          // Leave at mid stop bit so a start bit right after it is not missed.
          if (os_cnt == OS_MID) begin
            state_d = IDLE;
            if (rx_s) begin
              frame_done = 1'b1;
            end else begin
              stop_bad = 1'b1;
            end
          end else begin
            os_d = os_cnt + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output holding register with valid/ready handshake and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_idle = (state == IDLE);

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - self-checking bench for rx_frame_ctrl
module tb_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_idle;
  logic       frame_err;
  logic       overrun;

  localparam int BIT_CLKS = 64;

  rx_frame_ctrl #(.CLKS_PER_TICK(4), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_idle   (rx_idle),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int first_valid = -1;
  int ferr_n = 0;
  int ovr_n = 0;
  bit busy_seen = 0;
  bit rand_ready = 0;
  logic [7:0] acc_q[$];

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_ovr = 1'b0;
  logic [7:0] prev_data = 8'd0;

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    bit         spk;
    bit         exp_ok;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t tbl[6];

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: collects handshakes and pulses, checks hold and pulse-width rules.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (frame_err) ferr_n++;
      if (overrun) ovr_n++;
      if (!rx_idle) busy_seen = 1;
      if (rx_valid && first_valid < 0) first_valid = cyc;
      if (frame_err && prev_ferr) begin
        errors++;
        $display("FAIL frame_err_width actual 2+ cycles required 1 at cyc %0d", cyc);
      end
      if (overrun && prev_ovr) begin
        errors++;
        $display("FAIL overrun_width actual 2+ cycles required 1 at cyc %0d", cyc);
      end
      if (prev_valid && !prev_ready && rx_valid && rx_data !== prev_data) begin
        errors++;
        $display("FAIL data_hold actual %0h required %0h at cyc %0d", rx_data, prev_data, cyc);
      end
    end
    prev_valid = rx_valid;
    prev_ready = rx_ready;
    prev_ferr  = frame_err;
    prev_ovr   = overrun;
    prev_data  = rx_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    acc_q.delete();
    ferr_n = 0;
    ovr_n = 0;
    busy_seen = 0;
    first_valid = -1;
  endtask

  // Drives one 10-bit frame; optional spikes in data bits; optional reset at offset rst_at.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input bit spk, input int rst_at);
    start_cyc = cyc;
    for (int j = 0; j < 10 * BIT_CLKS; j++) begin
      int   b;
      int   p;
      logic lv;
      if (rst_at > 0 && j == rst_at) begin
        rx = 1'b1;
        rst_n = 1'b0;
        return;
      end
      b = j / BIT_CLKS;
      p = j % BIT_CLKS;
      if (b == 0) lv = 1'b0;
      else if (b <= 8) lv = d[b-1] ^ (spk && p >= 24 && p < 36);
      else lv = stop_v;
      rx = lv;
      step();
    end
    rx = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int exp_ferr;
    int lat;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    tbl[2] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 0};
    tbl[3] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 0};
    tbl[4] = '{8'h0F, 1'b1, 1'b1, 1'b1, 8'h0F, 0};
    tbl[5] = '{8'h96, 1'b1, 1'b1, 1'b1, 8'h96, 0};

    rst_n = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b0;
    repeat (3) step();
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_rx_idle", 32'(rx_idle), 32'd1);
    rst_n = 1'b1;
    repeat (10) step();

    // Directed frames, consumer always ready.
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      send_frame(tbl[i].data, tbl[i].stop_v, tbl[i].spk, 0);
      repeat (100) step();
      chk("tbl_count", 32'(acc_q.size()), tbl[i].exp_ok ? 32'd1 : 32'd0);
      if (tbl[i].exp_ok && acc_q.size() > 0) chk("tbl_data", 32'(acc_q[0]), 32'(tbl[i].exp_data));
      if (tbl[i].exp_ok) begin
        lat = first_valid - start_cyc;
        checks++;
        if (first_valid < 0 || lat < 610 || lat > 614) begin
          errors++;
          $display("FAIL latency actual %0d required 610..614", lat);
        end
      end
      chk("tbl_ferr", 32'(ferr_n), 32'(tbl[i].exp_ferr));
      chk("tbl_overrun", 32'(ovr_n), 32'd0);
      chk("tbl_idle", 32'(rx_idle), 32'd1);
      chk("tbl_valid_clear", 32'(rx_valid), 32'd0);
    end

    // Start-bit glitch: 20 clk low.
    clear_mon();
    rx = 1'b0;
    repeat (20) step();
    rx = 1'b1;
    repeat (100) step();
    chk("glitch_started", 32'(busy_seen), 32'd1);
    chk("glitch_idle", 32'(rx_idle), 32'd1);
    chk("glitch_no_valid", 32'(acc_q.size()), 32'd0);
    chk("glitch_no_valid_seen", 32'(first_valid < 0), 32'd1);
    chk("glitch_no_ferr", 32'(ferr_n), 32'd0);

    // Back-to-back frames with a stalled consumer.
    rx_ready = 1'b0;
    step();
    clear_mon();
    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 0);
    repeat (50) step();
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_data_held", 32'(rx_data), 32'h11);
    chk("ovr_pulses", 32'(ovr_n), 32'd1);
    rx_ready = 1'b1;
    step();
    chk("ovr_ready_clears", 32'(rx_valid), 32'd0);
    chk("ovr_accepted_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) chk("ovr_accepted_data", 32'(acc_q[0]), 32'h11);

    // Reset in the middle of data bit 4, with a held byte pending.
    rx_ready = 1'b0;
    clear_mon();
    send_frame(8'h77, 1'b1, 1'b0, 0);
    repeat (30) step();
    chk("rst_pre_valid", 32'(rx_valid), 32'd1);
    send_frame(8'hC3, 1'b1, 1'b0, 5 * BIT_CLKS + 20);
    #2;
    chk("rst_mid_valid", 32'(rx_valid), 32'd0);
    chk("rst_mid_data", 32'(rx_data), 32'd0);
    chk("rst_mid_ferr", 32'(frame_err), 32'd0);
    chk("rst_mid_ovr", 32'(overrun), 32'd0);
    chk("rst_mid_idle", 32'(rx_idle), 32'd1);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    rx_ready = 1'b1;
    clear_mon();
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    repeat (100) step();
    chk("rst_after_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) chk("rst_after_data", 32'(acc_q[0]), 32'h5A);
    chk("rst_after_ferr", 32'(ferr_n), 32'd0);

    // Random frames against a byte-queue reference; consumer ready is random.
    clear_mon();
    exp_q.delete();
    exp_ferr = 0;
    rand_ready = 1;
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      logic       st;
      bit         spk;
      int         gap;
      d   = 8'($urandom);
      st  = ($urandom_range(0, 3) != 0);
      spk = 1'($urandom_range(0, 1));
      send_frame(d, st, spk, 0);
      if (st) exp_q.push_back(d);
      else exp_ferr++;
      gap = st ? int'($urandom_range(0, 40)) : 40 + int'($urandom_range(0, 40));
      repeat (gap) step();
    end
    repeat (150) step();
    rand_ready = 0;
    step();
    rx_ready = 1'b1;
    repeat (5) step();
    chk("rand_count", 32'(acc_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      chk("rand_data", 32'(acc_q[i]), 32'(exp_q[i]));
    end
    chk("rand_ferr", 32'(ferr_n), 32'(exp_ferr));
    chk("rand_overrun", 32'(ovr_n), 32'd0);
    chk("rand_idle", 32'(rx_idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
